// File: rtl/floor_request_scheduler_if.sv
// Request/status bundle between the floor request scheduler and its requesters and drivers.
// slave = scheduler side, master = requester/driver side.
interface floor_request_scheduler_if #(
  parameter int FLOOR_W = 2,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               btn_req;
  logic [FLOOR_W-1:0] btn_floor;
  logic               btn_first;
  logic               btn_ack;
  logic               sw_req;
  logic [FLOOR_W-1:0] sw_floor;
  logic               sw_first;
  logic               sw_ack;
  logic [FLOOR_W-1:0] cur_floor;
  logic [FLOOR_W-1:0] target_floor;
  logic               target_valid;
  logic               move_up;
  logic               move_down;
  logic               door_open;
  logic [CNT_W-1:0]   q_count;
  logic               full;
  logic               empty;
  logic               drop;

  modport slave (
    input  btn_req, btn_floor, btn_first, sw_req, sw_floor, sw_first, cur_floor,
    output btn_ack, sw_ack, target_floor, target_valid, move_up, move_down,
           door_open, q_count, full, empty, drop
  );

  modport master (
    output btn_req, btn_floor, btn_first, sw_req, sw_floor, sw_first, cur_floor,
    input  btn_ack, sw_ack, target_floor, target_valid, move_up, move_down,
           door_open, q_count, full, empty, drop
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// Elevator scheduler: arbitrates hall/cab requests into a head/tail-insert queue and serves its head.
// Optional DOOR_REOPEN_EN: a same-floor request during dwell holds the door open instead of queueing.
module floor_request_scheduler #(
  parameter int FLOOR_W     = 2,
  parameter int DEPTH       = 4,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  floor_request_scheduler_if.slave    bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DW_W  = $clog2(DOOR_CYCLES);
  localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;

  logic [FLOOR_W-1:0] q_q [DEPTH];
  logic [FLOOR_W-1:0] q_d [DEPTH];
  logic [FLOOR_W-1:0] sh  [DEPTH];
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_pop;
  state_e             state_q, state_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic               rr_q, rr_d;
  logic               drop_q, drop_d;

  logic               empty_w, full_w, at_head, pop, reopen, merge, insert;
  logic               grant_btn, grant_sw, req_any, req_first;
  logic [FLOOR_W-1:0] req_floor;

  assign empty_w = (cnt_q == '0);
  assign full_w  = (cnt_q == CNT_W'(DEPTH));
  assign at_head = !empty_w && (q_q[0] == bus.cur_floor);

  // rr_q=0 favours the button; it only matters when both requesters are asserted
  assign grant_btn = bus.btn_req && (!bus.sw_req || !rr_q);
  assign grant_sw  = bus.sw_req && !grant_btn;
  assign req_any   = grant_btn || grant_sw;
  assign req_floor = grant_btn ? bus.btn_floor : bus.sw_floor;
  assign req_first = grant_btn ? bus.btn_first : bus.sw_first;

  always_comb begin
    reopen = 1'b0;
`ifdef DOOR_REOPEN_EN
    reopen = req_any && (state_q == DOOR) && (req_floor == bus.cur_floor);
`endif
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (at_head) begin
          state_d = DOOR; pop = 1'b1; dwell_d = DWELL_MAX;
        end else if (!empty_w) begin
          state_d = MOVE;
        end
      end
      MOVE: begin
        if (empty_w) begin
          state_d = IDLE;
        end else if (at_head) begin
          state_d = DOOR; pop = 1'b1; dwell_d = DWELL_MAX;
        end
      end
      DOOR: begin
        if (reopen) begin
          dwell_d = DWELL_MAX;
        end else if (dwell_q == '0) begin
          if (empty_w)      state_d = IDLE;
          else if (at_head) begin pop = 1'b1; dwell_d = DWELL_MAX; end
          else              state_d = MOVE;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // the entry leaving this cycle cannot absorb a request, so it is excluded from the merge match
  always_comb begin
    merge = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < cnt_q) && (q_q[i] == req_floor) && !(pop && i == 0)) merge = 1'b1;
    end
    insert = req_any && !reopen && !merge && !full_w;
    drop_d = req_any && !reopen && !merge && full_w;
    rr_d   = (bus.btn_req && bus.sw_req) ? grant_btn : rr_q;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) sh[i] = q_q[i];
    cnt_pop = cnt_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) sh[i] = q_q[i + 1];
      cnt_pop = cnt_q - 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) q_d[i] = sh[i];
    cnt_d = cnt_pop;
    if (insert) begin
      if (req_first) begin
        for (int i = 1; i < DEPTH; i++) q_d[i] = sh[i - 1];
        q_d[0] = req_floor;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == cnt_pop) q_d[i] = req_floor;
        end
      end
      cnt_d = cnt_pop + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      dwell_q <= '0;
      rr_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
      cnt_q   <= cnt_d;
      state_q <= state_d;
      dwell_q <= dwell_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.btn_ack      = grant_btn;
  assign bus.sw_ack       = grant_sw;
  assign bus.target_floor = empty_w ? '0 : q_q[0];
  assign bus.target_valid = !empty_w;
  assign bus.move_up      = (state_q == MOVE) && (bus.target_floor > bus.cur_floor);
  assign bus.move_down    = (state_q == MOVE) && (bus.target_floor < bus.cur_floor);
  assign bus.door_open    = (state_q == DOOR);
  assign bus.q_count      = cnt_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.drop         = drop_q;
endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler (FLOOR_W=2, DEPTH=4, DOOR_CYCLES=8).
module tb_floor_request_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  floor_request_scheduler_if #(.FLOOR_W(2), .DEPTH(4)) bus ();

  floor_request_scheduler #(.FLOOR_W(2), .DEPTH(4), .DOOR_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ba, sa;
    logic [1:0] tgt;
    logic       tv, up, dn, door;
    logic [2:0] cnt;
    logic       full, empty, drop;
  } out_t;

  typedef struct {
    bit         rst;
    bit         br;  logic [1:0] bf; bit bfirst;
    bit         sr;  logic [1:0] sf; bit sfirst;
    logic [1:0] cur;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];

  function automatic out_t o(bit ba, bit sa, int tgt, bit tv, bit up, bit dn, bit door,
                             int cnt, bit full, bit empty, bit drop);
    out_t r;
    r.ba = ba; r.sa = sa; r.tgt = 2'(tgt); r.tv = tv; r.up = up; r.dn = dn; r.door = door;
    r.cnt = 3'(cnt); r.full = full; r.empty = empty; r.drop = drop;
    return r;
  endfunction

  function automatic vec_t mk(bit rst, bit br, int bf, bit bfirst, bit sr, int sf, bit sfirst,
                              int cur, out_t e);
    vec_t v;
    v.rst = rst; v.br = br; v.bf = 2'(bf); v.bfirst = bfirst;
    v.sr = sr; v.sf = 2'(sf); v.sfirst = sfirst; v.cur = 2'(cur); v.exp = e;
    return v;
  endfunction

  function automatic out_t get_out();
    out_t r;
    r.ba = bus.btn_ack; r.sa = bus.sw_ack; r.tgt = bus.target_floor; r.tv = bus.target_valid;
    r.up = bus.move_up; r.dn = bus.move_down; r.door = bus.door_open; r.cnt = bus.q_count;
    r.full = bus.full; r.empty = bus.empty; r.drop = bus.drop;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(bit br, int bf, bit bfirst, bit sr, int sf, bit sfirst, int cur);
    bus.btn_req = br; bus.btn_floor = 2'(bf); bus.btn_first = bfirst;
    bus.sw_req = sr;  bus.sw_floor = 2'(sf);  bus.sw_first = sfirst;
    bus.cur_floor = 2'(cur);
  endtask

  // one cycle: inputs change after the falling edge, outputs sampled before the rising edge
  task automatic cyc(bit br, int bf, bit bfirst, bit sr, int sf, bit sfirst, int cur);
    @(negedge clk);
    drive(br, bf, bfirst, sr, sf, sfirst, cur);
    #2;
  endtask

  task automatic do_reset(int cur);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, cur);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_state", 32'(get_out()), 32'(o(0,0,0,0,0,0,0,0,0,1,0)));
    rst_n = 1'b1;

    // single tail request, travel 0->2, 8-cycle dwell, back to idle
    tbl.push_back(mk(1, 1,2,0, 0,0,0, 0, o(1,0,0,0,0,0,0,0,0,1,0)));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, o(0,0,2,1,0,0,0,1,0,0,0)));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, o(0,0,2,1,1,0,0,1,0,0,0)));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1, o(0,0,2,1,1,0,0,1,0,0,0)));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 2, o(0,0,2,1,0,0,0,1,0,0,0)));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0,0,0, 0,0,0, 2, o(0,0,0,0,0,0,1,0,0,1,0)));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 2, o(0,0,0,0,0,0,0,0,0,1,0)));
    // simultaneous requests: button wins, switch next cycle, queue {1,3}
    tbl.push_back(mk(1, 1,1,0, 1,3,0, 0, o(1,0,0,0,0,0,0,0,0,1,0)));
    tbl.push_back(mk(0, 0,0,0, 1,3,0, 0, o(0,1,1,1,0,0,0,1,0,0,0)));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 0, o(0,0,1,1,1,0,0,2,0,0,0)));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1, o(0,0,1,1,0,0,0,2,0,0,0)));
    tbl.push_back(mk(0, 0,0,0, 0,0,0, 1, o(0,0,3,1,0,0,1,1,0,0,0)));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (tbl[i].rst) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      drive(tbl[i].br, tbl[i].bf, tbl[i].bfirst, tbl[i].sr, tbl[i].sf, tbl[i].sfirst, tbl[i].cur);
      #2;
      chk($sformatf("vec%0d", i), 32'(get_out()), 32'(tbl[i].exp));
    end

    // head insert redirects a car already moving toward floor 3
    do_reset(0);
    cyc(1,3,0, 0,0,0, 0); chk("t3_ack3", 32'(bus.btn_ack), 1);
    cyc(0,0,0, 0,0,0, 0);
    cyc(0,0,0, 1,1,1, 0); chk("t3_up", 32'(bus.move_up), 1);
    chk("t3_ack1", 32'(bus.sw_ack), 1);
    cyc(0,0,0, 0,0,0, 0); chk("t3_tgt1", 32'(bus.target_floor), 1);
    chk("t3_cnt2", 32'(bus.q_count), 2);
    cyc(0,0,0, 0,0,0, 1); chk("t3_arrive", 32'(bus.move_up), 0);
    cyc(0,0,0, 0,0,0, 1); chk("t3_door", 32'(bus.door_open), 1);
    chk("t3_tgt3", 32'(bus.target_floor), 3);
    chk("t3_cnt1", 32'(bus.q_count), 1);

    // fill to DEPTH, merge at full, then a request for the entry being popped is dropped
    do_reset(0);
    cyc(1,1,0, 0,0,0, 0);
    cyc(1,2,0, 0,0,0, 0);
    cyc(1,3,0, 0,0,0, 0);
    cyc(1,0,0, 0,0,0, 0); chk("t4_ack0", 32'(bus.btn_ack), 1);
    cyc(1,2,0, 0,0,0, 0); chk("t4_full", 32'(bus.full), 1);
    chk("t4_cnt4", 32'(bus.q_count), 4);
    chk("t4_merge_ack", 32'(bus.btn_ack), 1);
    cyc(1,1,0, 0,0,0, 1); chk("t4_nodrop", 32'(bus.drop), 0);
    chk("t4_cnt_merge", 32'(bus.q_count), 4);
    chk("t4_full_ack", 32'(bus.btn_ack), 1);
    cyc(0,0,0, 0,0,0, 1); chk("t4_drop", 32'(bus.drop), 1);
    chk("t4_cnt_pop", 32'(bus.q_count), 3);
    chk("t4_tgt2", 32'(bus.target_floor), 2);
    cyc(0,0,0, 0,0,0, 1); chk("t4_drop_end", 32'(bus.drop), 0);

    // same-floor request during dwell
    do_reset(1);
    cyc(1,1,0, 0,0,0, 1);
    cyc(0,0,0, 0,0,0, 1);
    for (int i = 0; i < 4; i++) cyc(0,0,0, 0,0,0, 1);
    cyc(1,1,0, 0,0,0, 1); chk("t5_door", 32'(bus.door_open), 1);
    chk("t5_ack", 32'(bus.btn_ack), 1);
    cyc(0,0,0, 0,0,0, 1);
`ifdef DOOR_REOPEN_EN
    chk("t5_cnt", 32'(bus.q_count), 0);
`else
    chk("t5_cnt", 32'(bus.q_count), 1);
`endif
    n = 0;
    while (bus.door_open && n < 40) begin
      n++;
      cyc(0,0,0, 0,0,0, 1);
    end
`ifdef DOOR_REOPEN_EN
    chk("t5_door_len", 32'(n), 8);
`else
    chk("t5_door_len", 32'(n), 11);
`endif
    chk("t5_cnt_end", 32'(bus.q_count), 0);

    // asynchronous reset while moving down with three entries queued
    do_reset(3);
    cyc(1,0,0, 0,0,0, 3);
    cyc(1,1,0, 0,0,0, 3);
    cyc(1,2,0, 0,0,0, 3);
    cyc(0,0,0, 0,0,0, 3); chk("t6_down", 32'(bus.move_down), 1);
    chk("t6_cnt3", 32'(bus.q_count), 3);
    #1 rst_n = 1'b0;
    #1 chk("t6_async", 32'(get_out()), 32'(o(0,0,0,0,0,0,0,0,0,1,0)));
    @(posedge clk); #1;
    chk("t6_held", 32'(get_out()), 32'(o(0,0,0,0,0,0,0,0,0,1,0)));
    rst_n = 1'b1;
    cyc(0,0,0, 0,0,0, 3); chk("t6_after", 32'(get_out()), 32'(o(0,0,0,0,0,0,0,0,0,1,0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
